// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states and baud divisor helper.
// Also used by the receiver side for its bit timing.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } tx_state_t;

   function automatic int bit_cnt_calc(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with first-word fall-through head and occupancy count.
// Full/empty are decoded from the registered count.
module uart_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic                     rd_en,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] ONE = 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             wr_ok;
   logic             rd_ok;

   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);
   assign wr_ok = wr_en && !full;
   assign rd_ok = rd_en && !empty;
   assign dout  = mem[rd_ptr];

   // Storage array; no reset needed, contents are qualified by count.
   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr] <= din;
   end

   // Pointers wrap naturally at the power-of-two depth.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
         if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
         unique case ({wr_ok, rd_ok})
            2'b10:   count <= count + ONE;
            2'b01:   count <= count - ONE;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: byte FIFO feeding an 8-N-1 serialiser
// with optional parity bit ahead of the stop bit.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD       = 9600,
   parameter int FIFO_DEPTH = 16,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0
) (
   input  logic                          sys_clk,
   input  logic                          rst,
   input  logic [7:0]                    data_in,
   input  logic                          wr_en,
   output logic                          full,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          busy_flag,
   output logic                          tx
);

   localparam int BIT_CNT = bit_cnt_calc(CLK_FREQ, BAUD);
   localparam int TW      = $clog2(BIT_CNT);

   tx_state_t     state;
   tx_state_t     state_nxt;
   logic [TW-1:0] bit_tmr;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   logic          par;
   logic          pop;
   logic          tx_nxt;
   logic          bit_tick;
   logic          empty;
   logic [7:0]    head;

   uart_sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (sys_clk),
      .rst   (rst),
      .wr_en (wr_en),
      .rd_en (pop),
      .din   (data_in),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .count (fifo_count)
   );

   assign bit_tick = (bit_tmr == TW'(BIT_CNT - 1));

   // Next state, FIFO pop and the line level for the coming cycle.
   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      tx_nxt    = 1'b1;
      unique case (state)
         ST_IDLE: begin
            if (!empty) begin
               pop       = 1'b1;
               state_nxt = ST_START;
            end
         end
         ST_START: begin
            tx_nxt = 1'b0;
            if (bit_tick) state_nxt = ST_DATA;
         end
         ST_DATA: begin
            tx_nxt = shreg[0];
            if (bit_tick && bit_idx == 3'd7)
               state_nxt = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
         end
         ST_PARITY: begin
            tx_nxt = par;
            if (bit_tick) state_nxt = ST_STOP;
         end
         ST_STOP: begin
            tx_nxt = 1'b1;
            if (bit_tick) begin
               if (!empty) begin
                  pop       = 1'b1;
                  state_nxt = ST_START;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State register, bit timer, shift register and latched parity.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         bit_tmr <= '0;
         bit_idx <= '0;
         shreg   <= '0;
         par     <= 1'b0;
      end else begin
         state <= state_nxt;
         if (pop) begin
            shreg   <= head;
            par     <= (^head) ^ (PARITY_ODD != 0);
            bit_tmr <= '0;
            bit_idx <= '0;
         end else if (state != ST_IDLE) begin
            if (bit_tick) begin
               bit_tmr <= '0;
               if (state == ST_DATA) begin
                  shreg   <= shreg >> 1;
                  bit_idx <= bit_idx + 3'd1;
               end
            end else begin
               bit_tmr <= bit_tmr + TW'(1);
            end
         end
      end
   end

   // Registered line, overflow pulse and busy indication.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         tx        <= 1'b1;
         overflow  <= 1'b0;
         busy_flag <= 1'b0;
      end else begin
         tx        <= tx_nxt;
         overflow  <= wr_en && full;
         busy_flag <= (state_nxt != ST_IDLE) || (fifo_count != '0);
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised bench for uart_tx_fifo: three instances (no parity, even,
// odd) share one stimulus stream, each tracked by a frame-level model.
module tb_uart_tx_fifo;

   localparam int BITC  = 10;
   localparam int DEPTH = 16;

   logic       sys_clk = 1'b0;
   logic       rst     = 1'b1;
   logic [7:0] data_in = 8'h00;
   logic       wr_en   = 1'b0;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [10:0] frame_of(input logic [7:0] d,
                                            input int pe, input int po);
      logic [10:0] f;
      f      = '1;
      f[0]   = 1'b0;
      f[8:1] = d;
      if (pe != 0) f[9] = (^d) ^ (po != 0);
      return f;
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int PE = (g == 0) ? 0 : 1;
      localparam int PO = (g == 2) ? 1 : 0;
      localparam int FL = BITC * ((PE != 0) ? 11 : 10);

      logic       d_full;
      logic       d_ov;
      logic [4:0] d_cnt;
      logic       d_busy;
      logic       d_tx;

      uart_tx_fifo #(
         .CLK_FREQ   (1000),
         .BAUD       (100),
         .FIFO_DEPTH (DEPTH),
         .PARITY_EN  (PE),
         .PARITY_ODD (PO)
      ) u_dut (
         .sys_clk    (sys_clk),
         .rst        (rst),
         .data_in    (data_in),
         .wr_en      (wr_en),
         .full       (d_full),
         .overflow   (d_ov),
         .fifo_count (d_cnt),
         .busy_flag  (d_busy),
         .tx         (d_tx)
      );

      logic [7:0]  q[$];
      logic [10:0] pat    = '1;
      int          t      = FL + 1;
      int          rem    = 0;
      int          sz     = 0;
      bit          act    = 1'b0;
      bit          pop    = 1'b0;
      bit          e_ov   = 1'b0;
      bit          e_busy = 1'b0;
      bit          quiet  = 1'b1;

      initial forever begin
         @(posedge sys_clk or posedge rst);
         if (rst) begin
            q.delete();
            act    = 1'b0;
            rem    = 0;
            t      = FL + 1;
            e_ov   = 1'b0;
            e_busy = 1'b0;
         end else begin
            sz  = q.size();
            pop = (sz != 0) && (!act || rem == 1);
            if (pop) begin
               pat = frame_of(q.pop_front(), PE, PO);
               t   = 0;
               act = 1'b1;
               rem = FL;
            end else begin
               if (act) begin
                  rem--;
                  act = (rem != 0);
               end
               if (t <= FL) t++;
            end
            e_ov = wr_en && (sz == DEPTH);
            if (wr_en && sz < DEPTH) q.push_back(data_in);
            e_busy = act || (sz != 0);
         end
         quiet = !act && (q.size() == 0) && (t > FL);
      end

      always @(negedge sys_clk) begin
         chk($sformatf("i%0d_tx", g), d_tx,
             (t >= 1 && t <= FL) ? pat[(t - 1) / BITC] : 1'b1);
         chk($sformatf("i%0d_count", g), d_cnt, q.size());
         chk($sformatf("i%0d_full", g), d_full, q.size() == DEPTH);
         chk($sformatf("i%0d_overflow", g), d_ov, e_ov);
         chk($sformatf("i%0d_busy", g), d_busy, e_busy);
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge sys_clk);
         #1;
         data_in = 8'($urandom);
      end
   endtask

   task automatic put(input logic [7:0] d);
      wr_en   = 1'b1;
      data_in = d;
      @(posedge sys_clk);
      #1;
      wr_en   = 1'b0;
      data_in = 8'($urandom);
   endtask

   task automatic wait_quiet();
      int n;
      n = 0;
      while (!(g_dut[0].quiet && g_dut[1].quiet && g_dut[2].quiet)
             && n < 6000) begin
         idle(1);
         n++;
      end
      chk("quiet_timeout", n < 6000, 1'b1);
      idle(3);
   endtask

   initial begin
      idle(3);
      chk("rst_tx", g_dut[0].d_tx, 1'b1);
      chk("rst_count", g_dut[0].d_cnt, 0);
      chk("rst_busy", g_dut[0].d_busy, 1'b0);
      chk("rst_full", g_dut[0].d_full, 1'b0);
      rst = 1'b0;
      idle(2);

      put(8'h55);
      chk("single_tx_n", g_dut[0].d_tx, 1'b1);
      chk("single_busy_n", g_dut[0].d_busy, 1'b0);
      idle(1);
      chk("single_busy_n1", g_dut[0].d_busy, 1'b1);
      chk("single_cnt_n1", g_dut[0].d_cnt, 0);
      idle(1);
      chk("single_tx_fall", g_dut[0].d_tx, 1'b0);
      idle(10);
      chk("single_bit0", g_dut[0].d_tx, 1'b1);
      idle(88);
      chk("single_busy_n100", g_dut[0].d_busy, 1'b1);
      idle(1);
      chk("single_busy_n101", g_dut[0].d_busy, 1'b0);
      wait_quiet();

      put(8'hA5);
      put(8'h0F);
      put(8'hFF);
      chk("burst_cnt", g_dut[0].d_cnt, 2);
      idle(298);
      chk("burst_busy_300", g_dut[0].d_busy, 1'b1);
      idle(1);
      chk("burst_busy_301", g_dut[0].d_busy, 1'b0);
      wait_quiet();

      put(8'h11);
      for (int i = 0; i < DEPTH; i++) put(8'($urandom_range(0, 8'h98)));
      chk("fill_full", g_dut[0].d_full, 1'b1);
      put(8'h99);
      chk("fill_ovf", g_dut[0].d_ov, 1'b1);
      idle(1);
      chk("fill_ovf_end", g_dut[0].d_ov, 1'b0);
      wait_quiet();

      put(8'h07);
      idle(96);
      chk("par_even_bit", g_dut[1].d_tx, 1'b1);
      chk("par_odd_bit", g_dut[2].d_tx, 1'b0);
      idle(5);
      chk("par_none_done", g_dut[0].d_busy, 1'b0);
      chk("par_even_busy", g_dut[1].d_busy, 1'b1);
      idle(10);
      chk("par_even_done", g_dut[1].d_busy, 1'b0);
      wait_quiet();

      for (int i = 0; i < 5; i++) put(8'h31 + 8'(i));
      idle(32);
      rst = 1'b1;
      #1;
      chk("mid_rst_tx", g_dut[0].d_tx, 1'b1);
      chk("mid_rst_cnt", g_dut[0].d_cnt, 0);
      chk("mid_rst_busy", g_dut[0].d_busy, 1'b0);
      idle(2);
      rst = 1'b0;
      idle(250);
      chk("post_rst_quiet", g_dut[0].d_busy, 1'b0);
      wait_quiet();

      put(8'h22);
      for (int i = 0; i < DEPTH; i++) put(8'($urandom));
      wr_en   = 1'b1;
      data_in = 8'hC3;
      idle(130);
      wr_en = 1'b0;
      chk("refill_cnt", g_dut[0].d_cnt, DEPTH);
      chk("refill_full", g_dut[1].d_full, 1'b1);
      wait_quiet();

      for (int r = 0; r < 25; r++) begin
         int len;
         len = $urandom_range(1, 8);
         for (int k = 0; k < len; k++) put(8'($urandom));
         idle($urandom_range(0, 150));
      end
      wait_quiet();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
